// File: rtl/vend_pkg.sv
// Shared encodings for the vending dispense unit: FSM states, fault codes, product ids.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVend,
    StPay,
    StWaitCoin,
    StDone,
    StFault
  } vend_state_e;

  localparam logic [1:0] FaultNone      = 2'b00;
  localparam logic [1:0] FaultVendTo    = 2'b01;
  localparam logic [1:0] FaultCoinTo    = 2'b10;
  localparam logic [1:0] FaultCoinStuck = 2'b11;

  localparam logic PROD_CHOCO = 1'b0;
  localparam logic PROD_DRINK = 1'b1;

endpackage

// File: rtl/sensor_sync_edge.sv
// Two-flop synchronizer for an asynchronous sensor pin, followed by a rising-edge pulse.
module sensor_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sense_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sense_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/vend_dispense_unit.sv
// Dispense executor: runs the product motor, then ejects change coins one at a time.
// Optional build macro COIN_RETRY_EN re-pulses the hopper once per coin before faulting.
module vend_dispense_unit
  import vend_pkg::*;
#(
  parameter int unsigned CHANGE_W       = 3,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_product,
  input  logic [CHANGE_W-1:0] req_change,
  output logic                vend_motor,
  input  logic                vend_sense,
  output logic                coin_eject,
  input  logic                coin_sense,
  input  logic                fault_clr,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic                last_product,
  output logic [CHANGE_W-1:0] coins_paid
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax    = '1;
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] PulseLast   = TimerW'(PULSE_CYCLES - 1);

  vend_state_e         state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CHANGE_W-1:0] remain_q, remain_d;
  logic [CHANGE_W-1:0] paid_q, paid_d;
  logic                product_q, product_d;
  logic [1:0]          code_q, code_d;
  logic                confirmed_q, confirmed_d;
`ifdef COIN_RETRY_EN
  logic                retry_q, retry_d;
`endif

  logic timer_clr, take_coin;
  logic vend_level, vend_rise, coin_level, coin_rise;
  logic unused_vend_level;

  sensor_sync_edge u_vend_sync (
    .clk_i   (clk),
    .rst_ni  (reset),
    .sense_i (vend_sense),
    .level_o (vend_level),
    .rise_o  (vend_rise)
  );

  sensor_sync_edge u_coin_sync (
    .clk_i   (clk),
    .rst_ni  (reset),
    .sense_i (coin_sense),
    .level_o (coin_level),
    .rise_o  (coin_rise)
  );

  assign unused_vend_level = vend_level;

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    paid_d      = paid_q;
    product_d   = product_q;
    code_d      = code_q;
    confirmed_d = confirmed_q;
`ifdef COIN_RETRY_EN
    retry_d     = retry_q;
`endif
    timer_clr   = 1'b0;
    take_coin   = 1'b0;
    req_ready   = 1'b0;
    vend_motor  = 1'b0;
    coin_eject  = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          product_d   = req_product;
          remain_d    = req_change;
          paid_d      = '0;
          confirmed_d = 1'b0;
`ifdef COIN_RETRY_EN
          retry_d     = 1'b0;
`endif
          state_d     = StVend;
          timer_clr   = 1'b1;
        end
      end

      StVend: begin
        vend_motor = ~vend_rise;
        if (vend_rise) begin
          state_d   = (remain_q != '0) ? StPay : StDone;
          timer_clr = 1'b1;
        end else if (timer_q == TimeoutLast) begin
          state_d   = StFault;
          code_d    = FaultVendTo;
          timer_clr = 1'b1;
        end
      end

      StPay: begin
        // A sensor that is already high (not a fresh edge) on entry cannot confirm anything.
        if ((timer_q == '0) && coin_level && !coin_rise) begin
          state_d   = StFault;
          code_d    = FaultCoinStuck;
          timer_clr = 1'b1;
        end else begin
          coin_eject = 1'b1;
          if (coin_rise) begin
            confirmed_d = 1'b1;
          end
          if (timer_q == PulseLast) begin
            timer_clr = 1'b1;
            if (confirmed_q || coin_rise) begin
              take_coin = 1'b1;
            end else begin
              state_d = StWaitCoin;
            end
          end
        end
      end

      StWaitCoin: begin
        if (coin_rise) begin
          take_coin = 1'b1;
        end else if (timer_q == TimeoutLast) begin
          timer_clr = 1'b1;
`ifdef COIN_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = StPay;
          end else begin
            state_d = StFault;
            code_d  = FaultCoinTo;
          end
`else
          state_d = StFault;
          code_d  = FaultCoinTo;
`endif
        end
      end

      StDone: begin
        done      = 1'b1;
        state_d   = StIdle;
        timer_clr = 1'b1;
      end

      StFault: begin
        if (fault_clr) begin
          state_d   = StIdle;
          code_d    = FaultNone;
          timer_clr = 1'b1;
        end
      end

      default: begin
        state_d   = StIdle;
        timer_clr = 1'b1;
      end
    endcase

    if (take_coin) begin
      paid_d      = paid_q + 1'b1;
      remain_d    = remain_q - 1'b1;
      confirmed_d = 1'b0;
`ifdef COIN_RETRY_EN
      retry_d     = 1'b0;
`endif
      state_d     = (remain_q > CHANGE_W'(1)) ? StPay : StDone;
      timer_clr   = 1'b1;
    end

    if (timer_clr) begin
      timer_d = '0;
    end else if (timer_q == TimerMax) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      remain_q    <= '0;
      paid_q      <= '0;
      product_q   <= 1'b0;
      code_q      <= FaultNone;
      confirmed_q <= 1'b0;
`ifdef COIN_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remain_q    <= remain_d;
      paid_q      <= paid_d;
      product_q   <= product_d;
      code_q      <= code_d;
      confirmed_q <= confirmed_d;
`ifdef COIN_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign busy         = (state_q != StIdle) && (state_q != StFault);
  assign fault        = (state_q == StFault);
  assign fault_code   = code_q;
  assign last_product = product_q;
  assign coins_paid   = paid_q;

endmodule

// File: tb/tb_vend_dispense_unit.sv
// Scoreboard bench: each request pushes its expected completion/fault record; a monitor
// pops and compares whenever done pulses or fault rises.
module tb_vend_dispense_unit;

  localparam int unsigned CW = 3;
  localparam int unsigned PC = 4;
  localparam int unsigned TO = 16;
`ifdef COIN_RETRY_EN
  localparam int T4Pulses = 3;
`else
  localparam int T4Pulses = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_product = 1'b0;
  logic [CW-1:0] req_change = '0;
  logic          vend_sense = 1'b0;
  logic          coin_sense = 1'b0;
  logic          fault_clr = 1'b0;
  logic          req_ready, vend_motor, coin_eject, busy, done, fault, last_product;
  logic [1:0]    fault_code;
  logic [CW-1:0] coins_paid;

  always #5 clk = ~clk;

  vend_dispense_unit #(
    .CHANGE_W       (CW),
    .PULSE_CYCLES   (PC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_product  (req_product),
    .req_change   (req_change),
    .vend_motor   (vend_motor),
    .vend_sense   (vend_sense),
    .coin_eject   (coin_eject),
    .coin_sense   (coin_sense),
    .fault_clr    (fault_clr),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .last_product (last_product),
    .coins_paid   (coins_paid)
  );

  typedef struct {
    bit            is_fault;
    logic [1:0]    code;
    logic [CW-1:0] paid;
    logic          prod;
    int            pulses;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic exp_t mk(input bit f, input logic [1:0] c, input logic [CW-1:0] p,
                              input logic pr, input int np);
    exp_t e;
    e.is_fault = f;
    e.code     = c;
    e.paid     = p;
    e.prod     = pr;
    e.pulses   = np;
    return e;
  endfunction

  // Monitor: eject pulse bookkeeping plus scoreboard pops on done / fault rise.
  initial begin
    int   pulses;
    int   plen;
    logic ej_prev, f_prev, d_prev;
    exp_t e;
    pulses = 0; plen = 0; ej_prev = 1'b0; f_prev = 1'b0; d_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pulses = 0; plen = 0; ej_prev = 1'b0; f_prev = 1'b0; d_prev = 1'b0;
      end else begin
        if (req_valid && req_ready) pulses = 0;
        if (coin_eject) begin
          if (!ej_prev) pulses++;
          plen++;
        end else if (ej_prev) begin
          check("eject_len", plen, PC);
          plen = 0;
        end
        if (d_prev) check("done_width", done, 1'b0);
        if (done || (fault && !f_prev)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("evt_kind", fault, e.is_fault);
            check("evt_code", fault_code, e.code);
            check("evt_paid", coins_paid, e.paid);
            check("evt_prod", last_product, e.prod);
            check("evt_pulses", pulses, e.pulses);
          end
        end
        ej_prev = coin_eject;
        f_prev  = fault;
        d_prev  = done;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return done;
      1:       return fault;
      2:       return coin_eject;
      3:       return !coin_eject;
      default: return req_ready;
    endcase
  endfunction

  task automatic wait_until(input string name, input int which, input int budget);
    int k = 0;
    while (!probe(which) && k < budget) begin
      step(1);
      k++;
    end
    check(name, probe(which), 1'b1);
  endtask

  task automatic send(input logic prod, input logic [CW-1:0] chg, input exp_t e, input bit push);
    wait_until("ready_wait", 4, 50);
    if (push) exp_q.push_back(e);
    req_valid   = 1'b1;
    req_product = prod;
    req_change  = chg;
    step(1);
    req_valid   = 1'b0;
  endtask

  task automatic vend_pulse();
    vend_sense = 1'b1;
    step(1);
    vend_sense = 1'b0;
  endtask

  task automatic coin_pulse();
    coin_sense = 1'b1;
    step(1);
    coin_sense = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    step(2);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_code", fault_code, 2'b00);
    check("rst_motor", vend_motor, 1'b0);
    check("rst_eject", coin_eject, 1'b0);
    check("rst_paid", coins_paid, 3'd0);
    check("rst_prod", last_product, 1'b0);
    reset = 1'b1;
    step(2);

    // Drink, no change.
    send(1'b1, 3'd0, mk(1'b0, 2'b00, 3'd0, 1'b1, 0), 1'b1);
    check("t1_motor_on", vend_motor, 1'b1);
    check("t1_ready_busy", req_ready, 1'b0);
    check("t1_busy", busy, 1'b1);
    step(4);
    vend_pulse();
    wait_until("t1_done", 0, 20);
    check("t1_motor_off", vend_motor, 1'b0);
    check("t1_no_eject", coin_eject, 1'b0);
    step(1);
    check("t1_ready_after", req_ready, 1'b1);

    // Chocolate, two coins of change.
    send(1'b0, 3'd2, mk(1'b0, 2'b00, 3'd2, 1'b0, 2), 1'b1);
    step(3);
    vend_pulse();
    repeat (2) begin
      wait_until("t2_eject_on", 2, 20);
      wait_until("t2_eject_off", 3, 20);
      step(1);
      coin_pulse();
    end
    wait_until("t2_done", 0, 40);
    step(1);

    // Vend timeout, then fault_clr racing a request.
    send(1'b1, 3'd1, mk(1'b1, 2'b01, 3'd0, 1'b1, 0), 1'b1);
    n = 0;
    while (!fault && n < 40) begin
      step(1);
      n++;
    end
    check("t3_timeout_cycles", n, TO);
    check("t3_motor_off", vend_motor, 1'b0);
    check("t3_ready_fault", req_ready, 1'b0);
    check("t3_busy_fault", busy, 1'b0);
    fault_clr   = 1'b1;
    req_valid   = 1'b1;
    req_product = 1'b0;
    req_change  = 3'd3;
    step(1);
    fault_clr = 1'b0;
    req_valid = 1'b0;
    check("t3_clr_ready", req_ready, 1'b1);
    check("t3_clr_fault", fault, 1'b0);
    check("t3_clr_code", fault_code, 2'b00);
    check("t3_clr_not_accepted", busy, 1'b0);
    check("t3_clr_prod_kept", last_product, 1'b1);

    // Coin timeout after one of three coins.
    send(1'b0, 3'd3, mk(1'b1, 2'b10, 3'd1, 1'b0, T4Pulses), 1'b1);
    step(3);
    vend_pulse();
    wait_until("t4_eject_on", 2, 20);
    wait_until("t4_eject_off", 3, 20);
    step(1);
    coin_pulse();
    wait_until("t4_fault", 1, 200);
    check("t4_eject_off_fault", coin_eject, 1'b0);
    clear_fault();
    check("t4_paid_kept", coins_paid, 3'd1);
    check("t4_code_cleared", fault_code, 2'b00);

    // Coin sensor stuck high before PAY.
    send(1'b0, 3'd1, mk(1'b1, 2'b11, 3'd0, 1'b0, 0), 1'b1);
    coin_sense = 1'b1;
    step(3);
    vend_pulse();
    wait_until("t5_fault", 1, 30);
    check("t5_no_eject", coin_eject, 1'b0);
    coin_sense = 1'b0;
    clear_fault();
    step(2);

    // Asynchronous reset in the middle of an eject pulse.
    send(1'b0, 3'd2, mk(1'b0, 2'b00, 3'd0, 1'b0, 0), 1'b0);
    step(3);
    vend_pulse();
    wait_until("t6_eject_on", 2, 20);
    step(1);
    reset = 1'b0;
    #1;
    check("t6_eject_async", coin_eject, 1'b0);
    check("t6_busy_async", busy, 1'b0);
    check("t6_ready_async", req_ready, 1'b1);
    check("t6_paid_async", coins_paid, 3'd0);
    step(2);
    reset = 1'b1;
    step(1);
    check("t6_ready_release", req_ready, 1'b1);

    // A request held while busy must not be taken.
    send(1'b1, 3'd0, mk(1'b0, 2'b00, 3'd0, 1'b1, 0), 1'b1);
    req_valid   = 1'b1;
    req_product = 1'b0;
    req_change  = 3'd5;
    step(3);
    check("t6_busy_hold", busy, 1'b1);
    check("t6_prod_hold", last_product, 1'b1);
    req_valid = 1'b0;
    vend_pulse();
    wait_until("t6_done", 0, 20);
    step(2);
    check("t6_idle_after", req_ready, 1'b1);
    check("t6_prod_after", last_product, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
